// File: rtl/platformniossdram_pio_in_pkg.sv
// Shared constants for the PIO input port: Avalon word addresses and
// edge-type encodings used by the EDGE_TYPE parameter.
package platformniossdram_pio_in_pkg;

    // Avalon-MM word addresses
    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_RESERVED = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK  = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP  = 2'd3;

    // Capture edge selection
    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/platformniossdram_sync_chain.sv
// Multi-stage flop synchronizer bringing an asynchronous bus into the clk
// domain. The output is the last stage of the chain.
module platformniossdram_sync_chain #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] stages;

    // Shift the input through the chain; all stages clear on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            stages <= '0;
        end else begin
            stages[0] <= async_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign sync_out = stages[SYNC_STAGES-1];

endmodule

// File: rtl/platformniossdram_pio_in.sv
// Avalon-MM PIO input port with per-bit edge capture and optional interrupt.
// Map: 0 data (RO), 1 reserved, 2 irqmask (RW), 3 edgecapture (R/W1C).
// Define PLATFORMNIOSSDRAM_PIO_IN_IRQ_EN to build the irqmask register and
// irq logic; otherwise irq is tied low and address 2 reads zero.
module platformniossdram_pio_in
    import platformniossdram_pio_in_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] prev_in;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] irqmask;
    logic [31:0]      rd_mux;
    logic             rd_en;
    logic             wr_en;

    assign rd_en = chipselect & ~read_n;
    assign wr_en = chipselect & ~write_n;

    platformniossdram_sync_chain #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .async_in(in_port),
        .sync_out(sync_in)
    );

    // One-cycle delayed copy of the synchronized input for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_in <= '0;
        end else begin
            prev_in <= sync_in;
        end
    end

    generate
        if (EDGE_TYPE == EDGE_FALLING) begin : g_edge_fall
            assign edge_det = ~sync_in & prev_in;
        end else if (EDGE_TYPE == EDGE_ANY) begin : g_edge_any
            assign edge_det = sync_in ^ prev_in;
        end else begin : g_edge_rise
            assign edge_det = sync_in & ~prev_in;
        end
    endgenerate

    // Sticky capture; a new edge overrides a same-cycle W1C on that bit
    always_ff @(posedge clk) begin
        if (reset) begin
            edgecapture <= '0;
        end else if (wr_en && address == ADDR_EDGECAP) begin
            edgecapture <= (edgecapture & ~writedata[WIDTH-1:0]) | edge_det;
        end else begin
            edgecapture <= edgecapture | edge_det;
        end
    end

`ifdef PLATFORMNIOSSDRAM_PIO_IN_IRQ_EN
    logic irq_q;

    // Interrupt mask register, plain read/write
    always_ff @(posedge clk) begin
        if (reset) begin
            irqmask <= '0;
        end else if (wr_en && address == ADDR_IRQMASK) begin
            irqmask <= writedata[WIDTH-1:0];
        end
    end

    // Registered level interrupt from masked capture bits
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(edgecapture & irqmask);
        end
    end

    assign irq = irq_q;
`else
    assign irqmask = '0;
    assign irq     = 1'b0;
`endif

    // Read mux over current register values, so a same-cycle write is not seen
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:    rd_mux = 32'(sync_in);
            ADDR_IRQMASK: rd_mux = 32'(irqmask);
            ADDR_EDGECAP: rd_mux = 32'(edgecapture);
            default:      rd_mux = '0;
        endcase
    end

    // Read data register: loads on a read strobe, otherwise holds
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else if (rd_en) begin
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_platformniossdram_pio_in.sv
// Directed self-checking bench for platformniossdram_pio_in (rising-edge,
// 32-bit, 2-stage build). Interrupt checks follow the build macro
// PLATFORMNIOSSDRAM_PIO_IN_IRQ_EN.
module tb_platformniossdram_pio_in;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] in_port;
    logic [31:0] readdata;
    logic        irq;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] rd;

    always #5 clk = ~clk;

    platformniossdram_pio_in #(
        .WIDTH      (32),
        .EDGE_TYPE  (0),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .read_n    (read_n),
        .write_n   (write_n),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a; chipselect = 1'b1; read_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; read_n = 1'b1;
        d = readdata;
    endtask

    task automatic bus_rw(input logic [1:0] a, input logic [31:0] wd, output logic [31:0] d);
        address = a; writedata = wd; chipselect = 1'b1; read_n = 1'b0; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
        d = readdata;
    endtask

    initial begin
        reset = 1'b1; address = 2'd0; chipselect = 1'b0; read_n = 1'b1;
        write_n = 1'b1; writedata = '0; in_port = '0;
        cycles(3);
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_irq", {31'b0, irq}, 32'h0);
        reset = 1'b0;

        // no spurious capture after reset with a low input
        cycles(2);
        bus_read(2'd3, rd); chk("post_reset_edgecap", rd, 32'h0);

        // data read, one-cycle latency
        in_port = 32'hA5A5_0F0F;
        cycles(4);
        bus_read(2'd0, rd); chk("data_read", rd, 32'hA5A5_0F0F);
        bus_read(2'd3, rd); chk("rise_capture", rd, 32'hA5A5_0F0F);
        cycles(3);
        chk("readdata_hold", readdata, 32'hA5A5_0F0F);
        bus_write(2'd3, 32'h0000_0F00);
        bus_read(2'd3, rd); chk("partial_w1c", rd, 32'hA5A5_000F);
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_read(2'd3, rd); chk("full_w1c", rd, 32'h0);

        // reserved address
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_read(2'd1, rd); chk("reserved_read", rd, 32'h0);

        // falling edges ignored in rising mode
        in_port = 32'h0;
        cycles(4);
        bus_read(2'd3, rd); chk("fall_ignored", rd, 32'h0);
        bus_read(2'd0, rd); chk("data_zero", rd, 32'h0);

        // set wins over same-cycle clear on bit3; bit2 clears normally
        in_port = 32'h4;
        cycles(4);
        bus_read(2'd3, rd); chk("bit2_capture", rd, 32'h4);
        in_port = 32'hC;
        cycles(2);
        bus_write(2'd3, 32'hC);
        bus_read(2'd3, rd); chk("set_vs_clear", rd, 32'h8);

        // simultaneous read and W1C returns pre-write value
        bus_rw(2'd3, 32'h8, rd); chk("rw_prewrite", rd, 32'h8);
        bus_read(2'd3, rd); chk("rw_after", rd, 32'h0);

`ifdef PLATFORMNIOSSDRAM_PIO_IN_IRQ_EN
        in_port = 32'h0;
        cycles(4);
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_write(2'd2, 32'h1);
        bus_read(2'd2, rd); chk("irqmask_rw", rd, 32'h1);
        chk("irq_idle", {31'b0, irq}, 32'h0);
        in_port = 32'h1;
        cycles(4);
        chk("irq_rise", {31'b0, irq}, 32'h1);
        bus_read(2'd3, rd); chk("edgecap_bit0", rd, 32'h1);
        bus_write(2'd3, 32'h1);
        chk("irq_at_clear", {31'b0, irq}, 32'h1);
        cycles(1);
        chk("irq_after_clear", {31'b0, irq}, 32'h0);

        // masking
        bus_write(2'd2, 32'h0);
        in_port = 32'h0;
        cycles(4);
        in_port = 32'hFF;
        cycles(4);
        chk("irq_masked", {31'b0, irq}, 32'h0);
        bus_read(2'd3, rd); chk("edgecap_ff", rd, 32'hFF);
        bus_write(2'd2, 32'h80);
        chk("irq_mask_lag", {31'b0, irq}, 32'h0);
        cycles(1);
        chk("irq_unmasked", {31'b0, irq}, 32'h1);

        // reset mid-operation with a pending read
        bus_write(2'd2, 32'hFF);
        in_port = 32'h0;
        cycles(3);
        chk("irq_before_reset", {31'b0, irq}, 32'h1);
        reset = 1'b1; address = 2'd3; chipselect = 1'b1; read_n = 1'b0;
        @(negedge clk);
        reset = 1'b0; chipselect = 1'b0; read_n = 1'b1;
        chk("reset_mid_readdata", readdata, 32'h0);
        chk("reset_mid_irq", {31'b0, irq}, 32'h0);
        bus_read(2'd3, rd); chk("reset_mid_edgecap", rd, 32'h0);
        bus_read(2'd2, rd); chk("reset_mid_irqmask", rd, 32'h0);
`else
        // interrupt logic compiled out
        bus_write(2'd2, 32'hFFFF_FFFF);
        bus_read(2'd2, rd); chk("irqmask_absent", rd, 32'h0);
        in_port = 32'h1C;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("irq_tied_low", {31'b0, irq}, 32'h0);
        end
        bus_read(2'd3, rd); chk("edgecap_no_irq", rd, 32'h10);

        // reset mid-operation with a pending read
        in_port = 32'h0;
        reset = 1'b1; address = 2'd3; chipselect = 1'b1; read_n = 1'b0;
        @(negedge clk);
        reset = 1'b0; chipselect = 1'b0; read_n = 1'b1;
        chk("reset_mid_readdata", readdata, 32'h0);
        chk("reset_mid_irq", {31'b0, irq}, 32'h0);
        cycles(2);
        bus_read(2'd3, rd); chk("reset_mid_edgecap", rd, 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
